// File: rtl/mic_volume_meter_if.sv
// Microphone volume meter bus: sample strobe and mode in, meter results out.
// The source side (testbench or upstream logic) uses the master modport and
// the meter core uses the slave modport.
interface mic_volume_meter_if #(
  parameter int SAMPLE_W = 12,
  parameter int LED_N    = 12
);
  localparam int LVL_W = $clog2(LED_N + 1);

  logic                sample_en;
  logic [SAMPLE_W-1:0] sample;
  logic                mode;
  logic [SAMPLE_W-2:0] peak;
  logic                peak_valid;
  logic [LVL_W-1:0]    level;
  logic [LVL_W-1:0]    hold_level;
  logic [LED_N-1:0]    led;

  modport master (
    output sample_en, sample, mode,
    input  peak, peak_valid, level, hold_level, led
  );

  modport slave (
    input  sample_en, sample, mode,
    output peak, peak_valid, level, hold_level, led
  );
endinterface

// File: rtl/mic_volume_meter.sv
// Microphone volume meter.
// Tracks the peak amplitude |sample - MID| over windows of WINDOW accepted
// samples, quantises each window peak to an LED level and drives either a
// bar graph (mode=0) or the raw sample MSBs (mode=1).
// Optional peak-hold marker: define MIC_VOLUME_METER_HOLD_EN to build it;
// without the macro hold_level is tied to 0 and no hold logic exists.
module mic_volume_meter #(
  parameter int SAMPLE_W     = 12,
  parameter int LED_N        = 12,
  parameter int WINDOW       = 2000,
  parameter int HOLD_WINDOWS = 8
) (
  input logic              CLK,
  input logic              reset,
  mic_volume_meter_if.slave bus
);

  localparam int AMP_W  = SAMPLE_W - 1;
  localparam int LVL_W  = $clog2(LED_N + 1);
  localparam int CNT_W  = $clog2(WINDOW);
  localparam int PROD_W = AMP_W + LVL_W;

  localparam logic [SAMPLE_W-1:0] MID = {1'b1, {AMP_W{1'b0}}};

  // Reject parameter sets the datapath widths cannot represent.
  generate
    if (SAMPLE_W < 2 || LED_N < 1 || LED_N > SAMPLE_W || WINDOW < 2 || HOLD_WINDOWS < 0) begin : g_param_check
      $error("mic_volume_meter: illegal parameter combination");
    end
  endgenerate

  typedef enum logic {ACCUM = 1'b0, UPDATE = 1'b1} state_t;

  state_t              state_reg;
  state_t              state_next;
  logic                window_end;
  logic                is_update;

  logic [SAMPLE_W-1:0] diff;
  logic [AMP_W-1:0]    amp;
  logic [AMP_W-1:0]    acc_max;

  logic [AMP_W-1:0]    acc_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [AMP_W-1:0]    peak_reg;
  logic                peak_valid_reg;

  logic [PROD_W-1:0]   prod;
  logic [PROD_W:0]     sum;
  logic [PROD_W:0]     quo;
  logic [LVL_W-1:0]    level_calc;
  logic [LVL_W-1:0]    level_reg;
  logic [LVL_W-1:0]    level_next;
  logic [LVL_W-1:0]    hold_next;

  logic [LED_N-1:0]    bar;
  logic [LED_N-1:0]    led_reg;
  logic [LED_N-1:0]    led_next;

  // Amplitude: distance from midpoint; a sample of 0 gives MID which
  // does not fit in AMP_W bits, so it saturates to all ones.
  always_comb begin
    diff = MID - bus.sample;
    if (bus.sample[SAMPLE_W-1]) begin
      amp = bus.sample[AMP_W-1:0];
    end else if (diff[SAMPLE_W-1]) begin
      amp = '1;
    end else begin
      amp = diff[AMP_W-1:0];
    end
  end

  assign acc_max = (amp > acc_reg) ? amp : acc_reg;

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg <= ACCUM;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state: a window-closing strobe moves to UPDATE for one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACCUM:   if (window_end) state_next = UPDATE;
      UPDATE:  state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // FSM outputs: window-close detect and the level-refresh cycle.
  always_comb begin
    window_end = bus.sample_en && (cnt_reg == CNT_W'(WINDOW - 1));
    is_update  = (state_reg == UPDATE);
  end

  // Window accumulator; strobes count in either state so none are dropped.
  always_ff @(posedge CLK) begin
    if (reset) begin
      acc_reg        <= '0;
      cnt_reg        <= '0;
      peak_reg       <= '0;
      peak_valid_reg <= 1'b0;
    end else begin
      peak_valid_reg <= 1'b0;
      if (bus.sample_en) begin
        if (window_end) begin
          peak_reg       <= acc_max;
          peak_valid_reg <= 1'b1;
          acc_reg        <= '0;
          cnt_reg        <= '0;
        end else begin
          acc_reg <= acc_max;
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  // Quantised level: ceil(peak*LED_N / MID) clamped to LED_N, full-width product.
  always_comb begin
    prod       = PROD_W'(peak_reg) * PROD_W'(LED_N);
    sum        = {1'b0, prod} + {{(PROD_W + 1 - AMP_W){1'b0}}, {AMP_W{1'b1}}};
    quo        = sum >> AMP_W;
    level_calc = (quo > (PROD_W + 1)'(LED_N)) ? LVL_W'(LED_N) : quo[LVL_W-1:0];
    level_next = is_update ? level_calc : level_reg;
  end

  // Level register, refreshed only in the UPDATE cycle.
  always_ff @(posedge CLK) begin
    if (reset) begin
      level_reg <= '0;
    end else begin
      level_reg <= level_next;
    end
  end

`ifdef MIC_VOLUME_METER_HOLD_EN
  localparam int HCNT_W = (HOLD_WINDOWS > 0) ? $clog2(HOLD_WINDOWS + 1) : 1;

  logic [LVL_W-1:0]  hold_reg;
  logic [HCNT_W-1:0] hcnt_reg;
  logic [HCNT_W-1:0] hcnt_next;

  // Peak hold: capture a new high, sit for HOLD_WINDOWS updates, then decay by one per update.
  always_comb begin
    hold_next = hold_reg;
    hcnt_next = hcnt_reg;
    if (is_update) begin
      if (level_calc >= hold_reg) begin
        hold_next = level_calc;
        hcnt_next = HCNT_W'(HOLD_WINDOWS);
      end else if (hcnt_reg != '0) begin
        hcnt_next = hcnt_reg - HCNT_W'(1);
      end else if (hold_reg != '0) begin
        hold_next = hold_reg - LVL_W'(1);
      end
    end
  end

  // Peak-hold registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      hold_reg <= '0;
      hcnt_reg <= '0;
    end else begin
      hold_reg <= hold_next;
      hcnt_reg <= hcnt_next;
    end
  end

  assign bus.hold_level = hold_reg;
`else
  assign hold_next      = '0;
  assign bus.hold_level = '0;
`endif

  // Bar pattern: thermometer of the level plus a single hold marker bit.
  // Built from the next-cycle values so led and level change on the same edge.
  generate
    for (genvar gi = 0; gi < LED_N; gi++) begin : g_bar
      assign bar[gi] = (level_next > LVL_W'(gi)) || (hold_next == LVL_W'(gi + 1));
    end
  endgenerate

  // LED source select: raw MSBs latched per strobe, or the bar pattern.
  always_comb begin
    led_next = led_reg;
    if (bus.mode) begin
      if (bus.sample_en) begin
        led_next = bus.sample[SAMPLE_W-1 -: LED_N];
      end
    end else begin
      led_next = bar;
    end
  end

  // LED output register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      led_reg <= '0;
    end else begin
      led_reg <= led_next;
    end
  end

  assign bus.peak       = peak_reg;
  assign bus.peak_valid = peak_valid_reg;
  assign bus.level      = level_reg;
  assign bus.led        = led_reg;

endmodule

// File: tb/tb_mic_volume_meter.sv
// Self-checking bench for mic_volume_meter (SAMPLE_W=12, LED_N=12, WINDOW=4,
// HOLD_WINDOWS=2). A behavioural model predicts every output each cycle;
// directed scenarios add hand-computed expectations. Honours
// MIC_VOLUME_METER_HOLD_EN in the same way as the design.
module tb_mic_volume_meter;
  localparam int SW  = 12;
  localparam int LN  = 12;
  localparam int WIN = 4;
  localparam int HW  = 2;
  localparam int MID = 1 << (SW - 1);

  logic CLK;
  logic reset;

  mic_volume_meter_if #(.SAMPLE_W(SW), .LED_N(LN)) bus ();

  mic_volume_meter #(
    .SAMPLE_W(SW), .LED_N(LN), .WINDOW(WIN), .HOLD_WINDOWS(HW)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int pv_seen  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  m_amps[$];
  int  m_peak, m_pv, m_level, m_hold, m_hcnt, m_led;
  bit  m_valid = 1'b0;

  function automatic int amp_of(input int s);
    int d;
    d = s - MID;
    if (d < 0) d = -d;
    if (d > MID - 1) d = MID - 1;
    return d;
  endfunction

  function automatic int level_of(input int p);
    int l;
    l = (p * LN + MID - 1) / MID;
    if (l > LN) l = LN;
    return l;
  endfunction

  function automatic int bar_of(input int l, input int h);
    int r;
    r = 0;
    for (int i = 0; i < l; i++) r = r | (1 << i);
    if (h > 0) r = r | (1 << (h - 1));
    return r;
  endfunction

  always @(posedge CLK) begin
    int new_level;
    int new_hold;
    int new_pv;
    int mx;
    if (reset) begin
      m_amps.delete();
      m_peak = 0; m_pv = 0; m_level = 0; m_hold = 0; m_hcnt = 0; m_led = 0;
      m_valid = 1'b1;
    end else begin
      new_level = m_level;
      new_hold  = m_hold;
      new_pv    = 0;
      if (m_pv != 0) begin
        new_level = level_of(m_peak);
`ifdef MIC_VOLUME_METER_HOLD_EN
        if (new_level >= m_hold) begin
          new_hold = new_level;
          m_hcnt   = HW;
        end else if (m_hcnt > 0) begin
          m_hcnt = m_hcnt - 1;
        end else if (m_hold > 0) begin
          new_hold = m_hold - 1;
        end
`endif
      end
      if (bus.sample_en === 1'b1) begin
        m_amps.push_back(amp_of(int'(bus.sample)));
        if (m_amps.size() == WIN) begin
          mx = 0;
          foreach (m_amps[k]) if (m_amps[k] > mx) mx = m_amps[k];
          m_peak = mx;
          new_pv = 1;
          m_amps.delete();
        end
      end
      if (bus.mode === 1'b1) begin
        if (bus.sample_en === 1'b1) m_led = int'(bus.sample) >> (SW - LN);
      end else begin
        m_led = bar_of(new_level, new_hold);
      end
      m_level = new_level;
      m_hold  = new_hold;
      m_pv    = new_pv;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge CLK) begin
    if (m_valid) begin
      check("cyc_peak", 32'(bus.peak), 32'(m_peak));
      check("cyc_peak_valid", 32'(bus.peak_valid), 32'(m_pv));
      check("cyc_level", 32'(bus.level), 32'(m_level));
      check("cyc_hold_level", 32'(bus.hold_level), 32'(m_hold));
      check("cyc_led", 32'(bus.led), 32'(m_led));
      if (bus.peak_valid === 1'b1) pv_seen++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic strobe(input int v);
    @(negedge CLK); #1;
    bus.sample_en = 1'b1;
    bus.sample    = SW'(v);
    @(negedge CLK); #1;
    bus.sample_en = 1'b0;
  endtask

  task automatic window_of(input int v);
    for (int i = 0; i < WIN; i++) strobe(v);
  endtask

  task automatic settle();
    repeat (3) @(negedge CLK);
    #2;
  endtask

  int pv0;
  int burst[7] = '{12'h800, 12'h801, 12'h7FF, 12'h900, 12'h100, 12'h850, 12'h7F0};
  int exp_hold_seq[4];
  int exp_led_seq[4];

  initial begin
    reset         = 1'b1;
    bus.sample_en = 1'b0;
    bus.sample    = '0;
    bus.mode      = 1'b0;
    repeat (3) @(negedge CLK);
    #1 reset = 1'b0;
    #1;
    check("rst_peak", 32'(bus.peak), 0);
    check("rst_pv", 32'(bus.peak_valid), 0);
    check("rst_level", 32'(bus.level), 0);
    check("rst_hold", 32'(bus.hold_level), 0);
    check("rst_led", 32'(bus.led), 0);

    // Quiet window: midpoint samples.
    pv0 = pv_seen;
    window_of(2048);
    settle();
    check("quiet_peak", 32'(bus.peak), 0);
    check("quiet_pulses", 32'(pv_seen - pv0), 1);
    check("quiet_level", 32'(bus.level), 0);
    check("quiet_led", 32'(bus.led), 32'h000);

    // Half-scale peak.
    strobe(3072); strobe(2048); strobe(2048); strobe(2048);
    settle();
    check("half_peak", 32'(bus.peak), 1024);
    check("half_level", 32'(bus.level), 6);
    check("half_led", 32'(bus.led), 32'h03F);

    // Saturating extremes.
    window_of(0);
    settle();
    check("zero_peak", 32'(bus.peak), 2047);
    check("zero_level", 32'(bus.level), 12);
    check("zero_led", 32'(bus.led), 32'hFFF);
    window_of(4095);
    settle();
    check("full_peak", 32'(bus.peak), 2047);
    check("full_level", 32'(bus.level), 12);
    check("full_led", 32'(bus.led), 32'hFFF);

    // Hold and decay over quiet windows.
`ifdef MIC_VOLUME_METER_HOLD_EN
    exp_hold_seq = '{12, 12, 11, 10};
    exp_led_seq  = '{32'h800, 32'h800, 32'h400, 32'h200};
`else
    exp_hold_seq = '{0, 0, 0, 0};
    exp_led_seq  = '{0, 0, 0, 0};
`endif
    for (int w = 0; w < 4; w++) begin
      window_of(2048);
      settle();
      check("decay_level", 32'(bus.level), 0);
      check("decay_hold", 32'(bus.hold_level), 32'(exp_hold_seq[w]));
      check("decay_led", 32'(bus.led), 32'(exp_led_seq[w]));
    end

    // Reset mid-window, with a strobe in the reset cycle.
    pv0 = pv_seen;
    strobe(4095); strobe(4095); strobe(4095);
    @(negedge CLK); #1;
    reset = 1'b1; bus.sample_en = 1'b1; bus.sample = 12'hFFF;
    @(negedge CLK); #1;
    reset = 1'b0; bus.sample_en = 1'b0;
    #1;
    check("midrst_pulses", 32'(pv_seen - pv0), 0);
    check("midrst_peak", 32'(bus.peak), 0);
    check("midrst_level", 32'(bus.level), 0);
    check("midrst_hold", 32'(bus.hold_level), 0);
    check("midrst_led", 32'(bus.led), 0);
    strobe(2048); strobe(2048); strobe(2048);
    settle();
    check("postrst_3_pulses", 32'(pv_seen - pv0), 0);
    strobe(2048);
    settle();
    check("postrst_pulses", 32'(pv_seen - pv0), 1);
    check("postrst_peak", 32'(bus.peak), 0);

    // Raw mode and a strobe landing on the UPDATE cycle.
    @(negedge CLK); #1 bus.mode = 1'b1;
    strobe(12'hA5C);
    #1;
    check("raw_led", 32'(bus.led), 32'hA5C);
    pv0 = pv_seen;
    foreach (burst[i]) begin
      @(negedge CLK); #1;
      bus.sample_en = 1'b1;
      bus.sample    = SW'(burst[i]);
    end
    @(negedge CLK); #1 bus.sample_en = 1'b0;
    settle();
    check("burst_pulses", 32'(pv_seen - pv0), 2);
    check("burst_peak", 32'(bus.peak), 1792);
    check("burst_level", 32'(bus.level), 11);
    check("burst_raw_led", 32'(bus.led), 32'h7F0);
    @(negedge CLK); #1 bus.mode = 1'b0;
    @(negedge CLK); #2;
    check("bar_return_led", 32'(bus.led), 32'h7FF);

    // Randomised traffic checked by the model every cycle.
    for (int c = 0; c < 1500; c++) begin
      @(negedge CLK); #1;
      reset         = ($urandom_range(0, 299) == 0);
      bus.sample_en = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0:       bus.sample = '0;
        1:       bus.sample = '1;
        2:       bus.sample = SW'(2048 + $urandom_range(0, 64) - 32);
        default: bus.sample = SW'($urandom_range(0, 4095));
      endcase
      if ($urandom_range(0, 59) == 0) bus.mode = ~bus.mode;
    end
    @(negedge CLK); #1;
    reset = 1'b0; bus.sample_en = 1'b0;
    repeat (5) @(negedge CLK);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
